// File: rtl/uart_frame_sequencer.sv
// uart_frame_sequencer
// Collects NUM_BYTES received bytes into a frame buffer, waits for a debounced
// button press, then replays the frame through the UART transmitter in arrival
// order using a start/busy handshake.
// Optional build macro: UART_SEQ_CKSUM_EN appends one XOR checksum byte
// to every replayed frame.
//
// state     | meaning
// ----------+----------------------------------------------------------
// FILL      | storing bytes from the receiver
// FULL      | frame complete, waiting for a button press
// SEND      | waiting for an idle transmitter, then pulsing tx_start
// WAIT_ACK  | waiting for the transmitter to raise tx_busy
// WAIT_DONE | waiting for tx_busy to fall, then next byte or back to FILL

module uart_frame_sequencer #(
    parameter int NUM_BYTES = 8,
    parameter int THRESHOLD = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       tx_busy,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic       frame_full,
    output logic       sending,
    output logic       overflow,
    output logic [4:0] byte_cnt
);
    localparam int AW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam int DW = $clog2(THRESHOLD + 1);
    localparam logic [4:0]    LAST_DATA = 5'(NUM_BYTES - 1);
`ifdef UART_SEQ_CKSUM_EN
    localparam logic [4:0]    LAST_IDX  = 5'(NUM_BYTES);
`else
    localparam logic [4:0]    LAST_IDX  = 5'(NUM_BYTES - 1);
`endif
    localparam logic [DW-1:0] DEB_MAX   = DW'(THRESHOLD);
    localparam logic [DW-1:0] DEB_PRE   = DW'(THRESHOLD - 1);

    typedef enum logic [2:0] {
        S_FILL,
        S_FULL,
        S_SEND,
        S_WAIT_ACK,
        S_WAIT_DONE
    } state_t;

    state_t        state, state_nxt;
    logic [7:0]    buf_mem [NUM_BYTES];
    logic [DW-1:0] deb_cnt;
    logic          press;
    logic          store;
    logic          last_byte;
    logic [AW-1:0] rd_idx;
    logic [7:0]    nxt_byte;

    assign store      = (state == S_FILL) && rx_valid;
    assign last_byte  = (byte_cnt == LAST_IDX);
    assign rd_idx     = byte_cnt[AW-1:0] + 1'b1;
    assign frame_full = (state == S_FULL);
    assign sending    = (state == S_SEND) || (state == S_WAIT_ACK) || (state == S_WAIT_DONE);

`ifdef UART_SEQ_CKSUM_EN
    logic [7:0] cksum;

    // The byte after the last data byte is the running XOR of the frame
    assign nxt_byte = (byte_cnt == LAST_DATA) ? cksum : buf_mem[rd_idx];

    // Running XOR of stored bytes, cleared whenever the block re-enters FILL
    always_ff @(posedge clk) begin
        if (rst) begin
            cksum <= 8'h00;
        end else if (state == S_WAIT_DONE && state_nxt == S_FILL) begin
            cksum <= 8'h00;
        end else if (store) begin
            cksum <= cksum ^ rx_data;
        end
    end
`else
    assign nxt_byte = buf_mem[rd_idx];
`endif

    // Debounce: count consecutive high samples, saturate, pulse once on reaching THRESHOLD
    always_ff @(posedge clk) begin
        if (rst) begin
            deb_cnt <= '0;
            press   <= 1'b0;
        end else begin
            press <= btn && (deb_cnt == DEB_PRE);
            if (!btn) begin
                deb_cnt <= '0;
            end else if (deb_cnt != DEB_MAX) begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    // Frame buffer write; contents survive reset on purpose
    always_ff @(posedge clk) begin
        if (store && !rst) begin
            buf_mem[byte_cnt[AW-1:0]] <= rx_data;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FILL;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; tx_start is issued straight from SEND so a press reaches the wire next cycle
    always_comb begin
        state_nxt = state;
        tx_start  = 1'b0;
        case (state)
            S_FILL: begin
                if (rx_valid && byte_cnt == LAST_DATA) state_nxt = S_FULL;
            end
            S_FULL: begin
                if (press) state_nxt = S_SEND;
            end
            S_SEND: begin
                if (!tx_busy) begin
                    tx_start  = 1'b1;
                    state_nxt = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                if (tx_busy) state_nxt = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (!tx_busy) state_nxt = last_byte ? S_FILL : S_SEND;
            end
            default: state_nxt = S_FILL;
        endcase
    end

    // Byte count / send index, outgoing byte register and sticky overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt <= '0;
            tx_data  <= 8'h00;
            overflow <= 1'b0;
        end else begin
            if (rx_valid && state != S_FILL) overflow <= 1'b1;
            case (state)
                S_FILL: begin
                    if (rx_valid) byte_cnt <= byte_cnt + 5'd1;
                end
                S_FULL: begin
                    if (press) begin
                        byte_cnt <= '0;
                        tx_data  <= buf_mem[0];
                    end
                end
                S_WAIT_DONE: begin
                    if (!tx_busy) begin
                        if (last_byte) begin
                            byte_cnt <= '0;
                        end else begin
                            byte_cnt <= byte_cnt + 5'd1;
                            tx_data  <= nxt_byte;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_frame_sequencer.sv
// Bench for uart_frame_sequencer: a transmitter model answers tx_start with a
// tx_busy window and records every launched byte; each test compares the
// recorded bytes against the frame it fed in (plus XOR byte when
// UART_SEQ_CKSUM_EN is defined).

module tb_uart_frame_sequencer;
    localparam int NB  = 8;
    localparam int THR = 20;
`ifdef UART_SEQ_CKSUM_EN
    localparam int FLEN = NB + 1;
`else
    localparam int FLEN = NB;
`endif

    logic       clk = 1'b0;
    logic       rst, btn, rx_valid, tx_busy, tx_start, frame_full, sending, overflow;
    logic [7:0] rx_data, tx_data;
    logic [4:0] byte_cnt;
    logic       model_busy, hold_busy;
    int         busy_len, busy_left, proto_err;
    logic [7:0] obs_q[$];
    logic [7:0] frame_q[$];
    logic [7:0] exp_q[$];
    int         total, bad;

    assign tx_busy = model_busy | hold_busy;

    uart_frame_sequencer #(.NUM_BYTES(NB), .THRESHOLD(THR)) dut (
        .clk(clk), .rst(rst), .btn(btn), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
        .frame_full(frame_full), .sending(sending), .overflow(overflow), .byte_cnt(byte_cnt)
    );

    always #5 clk = ~clk;

    // Transmitter model: busy for busy_len cycles starting the cycle after tx_start
    initial begin
        logic start_now;
        logic busy_seen;
        model_busy = 1'b0;
        busy_left  = 0;
        proto_err  = 0;
        busy_seen  = 1'b1;
        forever begin
            @(negedge clk);
            if (tx_busy === 1'b1) busy_seen = 1'b1;
            start_now = (tx_start === 1'b1);
            if (start_now) begin
                if (!busy_seen) proto_err++;
                busy_seen = 1'b0;
                obs_q.push_back(tx_data);
            end
            @(posedge clk);
            #1;
            if (start_now) busy_left = busy_len;
            else if (busy_left > 0) busy_left--;
            model_busy = (busy_left > 0);
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick(1);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic hold_btn(input int n);
        btn = 1'b1;
        tick(n);
        btn = 1'b0;
        tick(1);
    endtask

    task automatic random_frame();
        frame_q.delete();
        for (int i = 0; i < NB; i++) frame_q.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic send_frame();
        for (int i = 0; i < NB; i++) begin
            send_byte(frame_q[i]);
            tick($urandom_range(0, 3));
        end
    endtask

    // Expected wire sequence: stored bytes in arrival order, then XOR if enabled
    task automatic make_exp();
        exp_q.delete();
        foreach (frame_q[i]) exp_q.push_back(frame_q[i]);
`ifdef UART_SEQ_CKSUM_EN
        begin
            logic [7:0] x;
            x = 8'h00;
            foreach (frame_q[i]) x = x ^ frame_q[i];
            exp_q.push_back(x);
        end
`endif
    endtask

    task automatic wait_frame(input int base, output bit ok);
        int cyc;
        cyc = 0;
        while ((obs_q.size() < base + FLEN || sending === 1'b1) && cyc < 4000) begin
            tick(1);
            cyc++;
        end
        ok = (cyc < 4000);
        tick(4);
    endtask

    task automatic test_reset();
        logic [7:0] got [6];
        string      nm [6];
        nm  = '{"tx_start", "tx_data", "frame_full", "sending", "overflow", "byte_cnt"};
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        got = '{8'(tx_start), tx_data, 8'(frame_full), 8'(sending), 8'(overflow), 8'(byte_cnt)};
        for (int i = 0; i < 6; i++) begin
            total++;
            if (got[i] !== 8'h00) begin
                bad++;
                $display("FAIL reset_%s got %h want 00", nm[i], got[i]);
            end
        end
    endtask

    task automatic test_fill_replay();
        int base;
        bit ok;
        busy_len = 12;
        base = obs_q.size();
        frame_q = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hab, 8'hcd, 8'hef};
        for (int i = 0; i < NB; i++) begin
            send_byte(frame_q[i]);
            if (i == NB - 2) begin
                total++;
                if (frame_full !== 1'b0 || byte_cnt !== 5'(NB - 1)) begin
                    bad++;
                    $display("FAIL fill_partial got full=%b cnt=%0d want full=0 cnt=%0d", frame_full, byte_cnt, NB - 1);
                end
            end
            if (i == NB - 1) begin
                total++;
                if (frame_full !== 1'b1 || byte_cnt !== 5'(NB)) begin
                    bad++;
                    $display("FAIL fill_full got full=%b cnt=%0d want full=1 cnt=%0d", frame_full, byte_cnt, NB);
                end
            end
            tick(1);
        end
        hold_btn(150);
        wait_frame(base, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL fill_timeout got no frame end want frame end"); end
        make_exp();
        total++;
        if (obs_q.size() - base !== FLEN) begin
            bad++;
            $display("FAIL fill_count got %0d want %0d", obs_q.size() - base, FLEN);
        end
        for (int i = 0; i < FLEN; i++) begin
            total++;
            if (obs_q[base + i] !== exp_q[i]) begin
                bad++;
                $display("FAIL fill_byte%0d got %h want %h", i, obs_q[base + i], exp_q[i]);
            end
        end
        total++;
        if (frame_full !== 1'b0 || byte_cnt !== 5'd0 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL fill_end got full=%b cnt=%0d ovf=%b want 0 0 0", frame_full, byte_cnt, overflow);
        end
    endtask

    task automatic test_debounce();
        int base, first;
        bit ok;
        busy_len = 6;
        random_frame();
        send_frame();
        base = obs_q.size();
        btn = 1'b1; tick(THR - 1); btn = 1'b0; tick(3);
        btn = 1'b1; tick(THR - 1); btn = 1'b0; tick(25);
        total++;
        if (obs_q.size() !== base || frame_full !== 1'b1) begin
            bad++;
            $display("FAIL debounce_short got starts=%0d full=%b want 0 1", obs_q.size() - base, frame_full);
        end
        btn = 1'b1;
        first = 0;
        for (int k = 1; k <= 40; k++) begin
            tick(1);
            if (first == 0 && tx_start === 1'b1) first = k;
        end
        btn = 1'b0;
        total++;
        if (first !== THR + 1) begin
            bad++;
            $display("FAIL debounce_latency got %0d want %0d", first, THR + 1);
        end
        wait_frame(base, ok);
        make_exp();
        total++;
        if (!ok || obs_q.size() - base !== FLEN) begin
            bad++;
            $display("FAIL debounce_count got %0d want %0d", obs_q.size() - base, FLEN);
        end
        for (int i = 0; i < FLEN; i++) begin
            total++;
            if (obs_q[base + i] !== exp_q[i]) begin
                bad++;
                $display("FAIL debounce_byte%0d got %h want %h", i, obs_q[base + i], exp_q[i]);
            end
        end
    endtask

    task automatic test_early_press();
        int base;
        bit ok;
        busy_len = 9;
        random_frame();
        base = obs_q.size();
        for (int i = 0; i < 4; i++) send_byte(frame_q[i]);
        hold_btn(30);
        tick(3);
        total++;
        if (obs_q.size() !== base || frame_full !== 1'b0 || byte_cnt !== 5'd4) begin
            bad++;
            $display("FAIL early_press got starts=%0d full=%b cnt=%0d want 0 0 4", obs_q.size() - base, frame_full, byte_cnt);
        end
        for (int i = 4; i < NB; i++) send_byte(frame_q[i]);
        total++;
        if (frame_full !== 1'b1) begin bad++; $display("FAIL early_full got %b want 1", frame_full); end
        tick(30);
        total++;
        if (obs_q.size() !== base || frame_full !== 1'b1) begin
            bad++;
            $display("FAIL early_wait got starts=%0d full=%b want 0 1", obs_q.size() - base, frame_full);
        end
        hold_btn(25);
        wait_frame(base, ok);
        make_exp();
        total++;
        if (!ok || obs_q.size() - base !== FLEN) begin
            bad++;
            $display("FAIL early_count got %0d want %0d", obs_q.size() - base, FLEN);
        end
        for (int i = 0; i < FLEN; i++) begin
            total++;
            if (obs_q[base + i] !== exp_q[i]) begin
                bad++;
                $display("FAIL early_byte%0d got %h want %h", i, obs_q[base + i], exp_q[i]);
            end
        end
    endtask

    task automatic test_busy();
        int base;
        bit ok;
        busy_len = 5;
        random_frame();
        send_frame();
        make_exp();
        base = obs_q.size();
        hold_busy = 1'b1;
        hold_btn(25);
        tick(20);
        total++;
        if (obs_q.size() !== base || sending !== 1'b1 || tx_start !== 1'b0 || byte_cnt !== 5'd0) begin
            bad++;
            $display("FAIL busy_hold got starts=%0d sending=%b start=%b cnt=%0d want 0 1 0 0",
                     obs_q.size() - base, sending, tx_start, byte_cnt);
        end
        @(posedge clk);
        #1;
        hold_busy = 1'b0;
        #1;
        total++;
        if (tx_start !== 1'b1 || tx_data !== exp_q[0]) begin
            bad++;
            $display("FAIL busy_release got start=%b data=%h want 1 %h", tx_start, tx_data, exp_q[0]);
        end
        tick(1);
        wait_frame(base, ok);
        total++;
        if (!ok || obs_q.size() - base !== FLEN) begin
            bad++;
            $display("FAIL busy_count got %0d want %0d", obs_q.size() - base, FLEN);
        end
        for (int i = 0; i < FLEN; i++) begin
            total++;
            if (obs_q[base + i] !== exp_q[i]) begin
                bad++;
                $display("FAIL busy_byte%0d got %h want %h", i, obs_q[base + i], exp_q[i]);
            end
        end
    endtask

    task automatic test_overflow();
        int base;
        bit ok;
        busy_len = 7;
        random_frame();
        for (int i = 0; i < NB; i++) if (frame_q[i] == 8'h55) frame_q[i] = 8'h5a;
        send_frame();
        base = obs_q.size();
        total++;
        if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_pre got %b want 0", overflow); end
        send_byte(8'h55);
        total++;
        if (overflow !== 1'b1 || frame_full !== 1'b1 || byte_cnt !== 5'(NB)) begin
            bad++;
            $display("FAIL ovf_set got ovf=%b full=%b cnt=%0d want 1 1 %0d", overflow, frame_full, byte_cnt, NB);
        end
        hold_btn(25);
        send_byte(8'h55);
        wait_frame(base, ok);
        make_exp();
        total++;
        if (!ok || obs_q.size() - base !== FLEN) begin
            bad++;
            $display("FAIL ovf_count got %0d want %0d", obs_q.size() - base, FLEN);
        end
        for (int i = 0; i < FLEN; i++) begin
            total++;
            if (obs_q[base + i] !== exp_q[i]) begin
                bad++;
                $display("FAIL ovf_byte%0d got %h want %h", i, obs_q[base + i], exp_q[i]);
            end
        end
        total++;
        if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got %b want 1", overflow); end
    endtask

    task automatic test_reset_mid_send();
        int base, cyc, starts_in_rst;
        bit ok;
        logic [7:0] got [6];
        string      nm [6];
        nm = '{"tx_start", "tx_data", "frame_full", "sending", "overflow", "byte_cnt"};
        busy_len = 10;
        random_frame();
        send_frame();
        base = obs_q.size();
        hold_btn(25);
        cyc = 0;
        while (obs_q.size() < base + 3 && cyc < 1000) begin tick(1); cyc++; end
        total++;
        if (cyc >= 1000) begin bad++; $display("FAIL midrst_reach got %0d starts want 3", obs_q.size() - base); end
        tick(2);
        rst = 1'b1;
        tick(1);
        got = '{8'(tx_start), tx_data, 8'(frame_full), 8'(sending), 8'(overflow), 8'(byte_cnt)};
        for (int i = 0; i < 6; i++) begin
            total++;
            if (got[i] !== 8'h00) begin
                bad++;
                $display("FAIL midrst_%s got %h want 00", nm[i], got[i]);
            end
        end
        starts_in_rst = 0;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            if (tx_start !== 1'b0) starts_in_rst++;
        end
        rst = 1'b0;
        tick(1);
        if (tx_start !== 1'b0) starts_in_rst++;
        total++;
        if (starts_in_rst !== 0) begin bad++; $display("FAIL midrst_quiet got %0d starts want 0", starts_in_rst); end
        base = obs_q.size();
        frame_q = '{8'hef, 8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hab, 8'hcd};
        send_frame();
        hold_btn(25);
        wait_frame(base, ok);
        make_exp();
        total++;
        if (!ok || obs_q.size() - base !== FLEN) begin
            bad++;
            $display("FAIL midrst_count got %0d want %0d", obs_q.size() - base, FLEN);
        end
        for (int i = 0; i < FLEN; i++) begin
            total++;
            if (obs_q[base + i] !== exp_q[i]) begin
                bad++;
                $display("FAIL midrst_byte%0d got %h want %h", i, obs_q[base + i], exp_q[i]);
            end
        end
        total++;
        if (overflow !== 1'b0) begin bad++; $display("FAIL midrst_ovf got %b want 0", overflow); end
    endtask

    task automatic test_random();
        int base;
        bit ok;
        logic exp_ovf;
        exp_ovf = 1'b0;
        for (int r = 0; r < 4; r++) begin
            busy_len = $urandom_range(1, 15);
            random_frame();
            send_frame();
            base = obs_q.size();
            tick($urandom_range(0, 10));
            hold_btn($urandom_range(THR + 1, 60));
            if (r == 2) begin
                send_byte(8'($urandom_range(0, 255)));
                exp_ovf = 1'b1;
            end
            wait_frame(base, ok);
            make_exp();
            total++;
            if (!ok || obs_q.size() - base !== FLEN) begin
                bad++;
                $display("FAIL rand%0d_count got %0d want %0d", r, obs_q.size() - base, FLEN);
            end
            for (int i = 0; i < FLEN; i++) begin
                total++;
                if (obs_q[base + i] !== exp_q[i]) begin
                    bad++;
                    $display("FAIL rand%0d_byte%0d got %h want %h", r, i, obs_q[base + i], exp_q[i]);
                end
            end
            total++;
            if (overflow !== exp_ovf || frame_full !== 1'b0 || byte_cnt !== 5'd0) begin
                bad++;
                $display("FAIL rand%0d_end got ovf=%b full=%b cnt=%0d want %b 0 0", r, overflow, frame_full, byte_cnt, exp_ovf);
            end
        end
        total++;
        if (proto_err !== 0) begin bad++; $display("FAIL handshake got %0d back-to-back starts want 0", proto_err); end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        busy_len  = 12;
        rst       = 1'b1;
        btn       = 1'b0;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        hold_busy = 1'b0;
        tick(2);
        test_reset();
        test_fill_replay();
        test_debounce();
        test_early_press();
        test_busy();
        test_overflow();
        test_reset_mid_send();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
